// File: rtl/reg_trace_buffer_if.sv
// Output stream of the register-write trace buffer: head entry plus valid/ready handshake.
interface reg_trace_buffer_if #(
  parameter int unsigned DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_reg;
  logic [DATA_W-1:0] out_data;

  // Producer side (the trace buffer).
  modport master (
    output out_valid,
    output out_reg,
    output out_data,
    input  out_ready
  );

  // Consumer side.
  modport slave (
    input  out_valid,
    input  out_reg,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/reg_trace_buffer.sv
// First-word-fall-through FIFO capturing core register-file writes until HALT.
// Optional TRACE_DROP_CNT_EN adds a saturating 16-bit count of dropped writes.
module reg_trace_buffer #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     reg_write_sig,
  input  logic [4:0]               reg_num,
  input  logic [DATA_W-1:0]        reg_data,
  input  logic                     halted,
  reg_trace_buffer_if.master       trace,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
`ifdef TRACE_DROP_CNT_EN
  output logic [15:0]              drop_cnt,
`endif
  output logic                     drained
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [4:0]        mem_reg  [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          halt_seen_q, halt_seen_d;

  logic valid;
  logic full;
  logic push;
  logic pop;
  logic accept;
  logic drop;

  assign valid = (count_q != '0);
  assign full  = (count_q == CW'(DEPTH));

  // halt_seen_q is still low in the cycle halted first rises, so that write still enqueues.
  assign push   = reg_write_sig & (reg_num != 5'd0) & ~halt_seen_q;
  assign pop    = valid & trace.out_ready;
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | drop;
    halt_seen_d = halt_seen_q | halted;
    if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      halt_seen_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      halt_seen_q <= halt_seen_d;
    end
  end

  // Storage is deliberately unreset; the outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_reg[wr_ptr_q]  <= reg_num;
      mem_data[wr_ptr_q] <= reg_data;
    end
  end

`ifdef TRACE_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hffff)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign trace.out_valid = valid;
  assign trace.out_reg   = valid ? mem_reg[rd_ptr_q]  : 5'd0;
  assign trace.out_data  = valid ? mem_data[rd_ptr_q] : '0;
  assign count           = count_q;
  assign overflow        = overflow_q;
  assign drained         = halt_seen_q & ~valid;

endmodule

// File: tb/tb_reg_trace_buffer.sv
// Randomized and directed checks of reg_trace_buffer against a queue-based reference model.
module tb_reg_trace_buffer;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              reg_write_sig = 1'b0;
  logic [4:0]        reg_num = '0;
  logic [DATA_W-1:0] reg_data = '0;
  logic              halted = 1'b0;
  logic [3:0]        count;
  logic              overflow;
  logic              drained;
`ifdef TRACE_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  reg_trace_buffer_if #(.DATA_W(DATA_W)) tr_if ();

  reg_trace_buffer #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .reg_write_sig (reg_write_sig),
    .reg_num       (reg_num),
    .reg_data      (reg_data),
    .halted        (halted),
    .trace         (tr_if.master),
    .count         (count),
    .overflow      (overflow),
`ifdef TRACE_DROP_CNT_EN
    .drop_cnt      (drop_cnt),
`endif
    .drained       (drained)
  );

  always #5 clk = ~clk;

  // Reference model: queue of {reg, data}, plus sticky flags.
  typedef struct packed {
    logic [4:0]        r;
    logic [DATA_W-1:0] d;
  } entry_t;

  entry_t m_q[$];
  bit     m_ovf;
  bit     m_halt;
  int     m_drops;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    entry_t head;
    head = (m_q.size() != 0) ? m_q[0] : '0;
    check({tag, ".valid"}, 64'(tr_if.out_valid), 64'(m_q.size() != 0));
    check({tag, ".reg"},   64'(tr_if.out_reg), 64'(head.r));
    check({tag, ".data"},  64'(tr_if.out_data), 64'(head.d));
    check({tag, ".count"}, 64'(count), 64'(m_q.size()));
    check({tag, ".ovf"},   64'(overflow), 64'(m_ovf));
    check({tag, ".drained"}, 64'(drained), 64'(m_halt && m_q.size() == 0));
`ifdef TRACE_DROP_CNT_EN
    check({tag, ".drops"}, 64'(drop_cnt), 64'((m_drops > 65535) ? 65535 : m_drops));
`endif
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input string tag, input logic wr, input logic [4:0] num,
                      input logic [DATA_W-1:0] data, input logic hlt, input logic rdy);
    bit do_pop, do_push;
    reg_write_sig   = wr;
    reg_num         = num;
    reg_data        = data;
    halted          = hlt;
    tr_if.out_ready = rdy;
    do_pop  = rdy && (m_q.size() != 0);
    do_push = wr && (num != 0) && !m_halt;
    @(posedge clk);
    if (do_pop) void'(m_q.pop_front());
    if (do_push) begin
      if (m_q.size() < DEPTH) m_q.push_back('{r: num, d: data});
      else begin
        m_ovf = 1'b1;
        m_drops++;
      end
    end
    if (hlt) m_halt = 1'b1;
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input logic rdy);
    step(tag, 1'b0, 5'd0, '0, 1'b0, rdy);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #2;
    check({tag, ".rst_count"}, 64'(count), 64'd0);
    check({tag, ".rst_valid"}, 64'(tr_if.out_valid), 64'd0);
    check({tag, ".rst_ovf"},   64'(overflow), 64'd0);
    check({tag, ".rst_reg"},   64'(tr_if.out_reg), 64'd0);
    check({tag, ".rst_data"},  64'(tr_if.out_data), 64'd0);
    check({tag, ".rst_drained"}, 64'(drained), 64'd0);
    m_q.delete();
    m_ovf   = 1'b0;
    m_halt  = 1'b0;
    m_drops = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    tr_if.out_ready = 1'b0;
    #3;
    do_reset("init");

    // Two consecutive writes drained with ready held high.
    step("w5", 1'b1, 5'd5, 32'h11, 1'b0, 1'b1);
    check("w5.cnt", 64'(count), 64'd1);
    check("w5.head", 64'(tr_if.out_reg), 64'd5);
    step("w6", 1'b1, 5'd6, 32'h22, 1'b0, 1'b1);
    check("w6.cnt", 64'(count), 64'd1);
    check("w6.head", 64'(tr_if.out_data), 64'h22);
    idle("w6pop", 1'b1);
    check("w6pop.cnt", 64'(count), 64'd0);

    // Writes to x0 never enqueue.
    step("x0", 1'b1, 5'd0, 32'hdead, 1'b0, 1'b0);
    check("x0.cnt", 64'(count), 64'd0);
    check("x0.valid", 64'(tr_if.out_valid), 64'd0);

    // Overflow: ten writes into an eight-deep FIFO, then drain in order.
    do_reset("ovf");
    for (int i = 1; i <= 10; i++) step("ovf.w", 1'b1, 5'(i), 32'(i * 16), 1'b0, 1'b0);
    check("ovf.cnt", 64'(count), 64'd8);
    check("ovf.flag", 64'(overflow), 64'd1);
`ifdef TRACE_DROP_CNT_EN
    check("ovf.drops", 64'(drop_cnt), 64'd2);
`endif
    for (int i = 1; i <= 8; i++) begin
      check("ovf.order", 64'(tr_if.out_reg), 64'(i));
      idle("ovf.drain", 1'b1);
    end
    check("ovf.empty", 64'(tr_if.out_valid), 64'd0);
    check("ovf.sticky", 64'(overflow), 64'd1);

    // Push into a full FIFO in the same cycle as a pop.
    do_reset("full");
    for (int i = 1; i <= 8; i++) step("full.w", 1'b1, 5'(i), 32'(i), 1'b0, 1'b0);
    step("full.pp", 1'b1, 5'd9, 32'h99, 1'b0, 1'b1);
    check("full.cnt", 64'(count), 64'd8);
    check("full.ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 7; i++) idle("full.drain", 1'b1);
    check("full.last_reg", 64'(tr_if.out_reg), 64'd9);
    check("full.last_data", 64'(tr_if.out_data), 64'h99);
    idle("full.end", 1'b1);

    // Halt with three entries queued; later writes ignored, drained after third pop.
    do_reset("halt");
    for (int i = 1; i <= 3; i++) step("halt.w", 1'b1, 5'(i + 10), 32'(i), 1'b0, 1'b0);
    step("halt.h", 1'b0, 5'd0, '0, 1'b1, 1'b0);
    step("halt.ign", 1'b1, 5'd20, 32'h5a, 1'b1, 1'b0);
    check("halt.cnt", 64'(count), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check("halt.drained_early", 64'(drained), 64'd0);
      step("halt.drain", 1'b1, 5'd21, 32'h77, 1'b0, 1'b1);
    end
    check("halt.drained", 64'(drained), 64'd1);

    // Reset mid-operation with four entries queued; next push lands at index 0.
    do_reset("mid");
    for (int i = 1; i <= 4; i++) step("mid.w", 1'b1, 5'(i), 32'(i), 1'b0, 1'b0);
    do_reset("mid2");
    step("mid.after", 1'b1, 5'd7, 32'h70, 1'b0, 1'b0);
    check("mid.idx0", 64'(dut.mem_reg[0]), 64'd7);

    // Randomized traffic.
    do_reset("rnd");
    for (int c = 0; c < 3000; c++) begin
      logic wr, hlt, rdy;
      logic [4:0] num;
      wr  = ($urandom_range(0, 3) != 0);
      num = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      hlt = ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      step("rnd", wr, num, DATA_W'($urandom), hlt, rdy);
      if ($urandom_range(0, 399) == 0) do_reset("rnd.rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/reg_trace_buffer.md
REG_TRACE_BUFFER -- requirements
Module: reg_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port reg_write_sig  input  1  core register-file write strobe for this cycle.
REQ-006 SHALL have port reg_num  input  5  destination register of the write.
REQ-007 SHALL have port reg_data  input  DATA_W  value written.
REQ-008 SHALL have port halted  input  1  core HALT status.
REQ-009 SHALL have port out_valid  output  1  head entry available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-011 SHALL have port out_reg  output  5  head entry register number.
REQ-012 SHALL have port out_data  output  DATA_W  head entry data.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port overflow  output  1  sticky: at least one write was lost.
REQ-015 SHALL have port drained  output  1  halt seen and FIFO empty.

Function
REQ-016 SHALL form push = reg_write_sig & (reg_num != 0) & ~halt_seen; writes to x0 never enqueue.
REQ-017 SHALL form pop = out_valid & out_ready.
REQ-018 SHALL be first-word-fall-through: out_valid = (count != 0); out_reg/out_data reflect the head entry combinationally from stored state.
REQ-019 SHALL make an entry pushed at edge N visible on out_valid after edge N (one-cycle latency); no input-to-output combinational path.
REQ-020 SHALL accept push when count < DEPTH, or when count == DEPTH and pop in the same cycle.
REQ-021 SHALL, on simultaneous accepted push and pop, leave count unchanged and advance both pointers.
REQ-022 SHALL, on push while full with no pop, drop the write, leave contents unchanged and set overflow (held until reset).
REQ-023 SHALL ignore out_ready when out_valid is 0 (no pointer movement, count stays 0).
REQ-024 SHALL wrap read/write pointers modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-025 SHALL set internal halt_seen on the first cycle halted = 1 and keep it until reset; a push in the same cycle halted first rises SHALL still be accepted.
REQ-026 SHALL keep draining after halt_seen; drained = halt_seen & (count == 0).
REQ-027 SHALL hold out_reg/out_data stable while out_valid = 1 and out_ready = 0.

Reset
REQ-028 SHALL, on reset low, asynchronously clear pointers, count, overflow, halt_seen (and drop counter when enabled); out_valid = 0, drained = 0.
REQ-029 SHALL drive out_reg = 0 and out_data = 0 while count == 0, including after reset; storage array need not be reset.
REQ-030 SHALL discard all buffered entries on reset asserted mid-operation; first push after release is stored at index 0.

Configuration
REQ-031 SHALL, with macro TRACE_DROP_CNT_EN defined, add output drop_cnt (16 bits) counting writes lost per REQ-022, saturating at 0xFFFF, reset to 0.
REQ-032 SHALL, without TRACE_DROP_CNT_EN, omit port drop_cnt and its logic; all other behaviour identical.

Verification
REQ-033 SHALL cover: reset release, writes x5=0x11, x6=0x22 in consecutive cycles, out_ready=1 -> out (5,0x11) then (6,0x22), count 1,1,0 per cycle.
REQ-034 SHALL cover: reg_write_sig=1, reg_num=0, reg_data=0xDEAD -> count stays 0, out_valid stays 0.
REQ-035 SHALL cover: DEPTH=8, out_ready=0, 10 writes x1..x10 -> count=8, overflow=1, drop_cnt=2 (macro on); draining yields x1..x8 in order.
REQ-036 SHALL cover: full FIFO, push x9=0x99 with out_ready=1 same cycle -> count stays 8, overflow stays 0, x9 emerges last.
REQ-037 SHALL cover: halted=1 with 3 entries queued, further writes after halt -> writes ignored, 3 entries drain, drained=1 after the third pop.
REQ-038 SHALL cover: reset low with 4 entries queued -> count=0, out_valid=0, overflow=0 immediately, without a clock edge.
